fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, SHALL be the PC loaded on reset; bits [1:0] are ignored and treated as 00.
REQ-002 Parameter ACK_TIMEOUT, default 16, SHALL be the number of REQ cycles without imem_ack that triggers the error state; legal range 1..255.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 imem_req  output  1  SHALL be the instruction-memory read request.
REQ-006 imem_addr  output  32  SHALL be the fetch address, word-aligned ([1:0]=00).
REQ-007 imem_ack  input  1  SHALL be the memory acknowledge; imem_rdata valid in the same cycle.
REQ-008 imem_rdata  input  32  SHALL be the fetched instruction word.
REQ-009 instr  output  32  SHALL be the held instruction presented to control/alu_control ([31:26] op, [5:0] funct).
REQ-010 instr_valid  output  1  SHALL indicate that instr and pc are valid.
REQ-011 instr_ready  input  1  SHALL indicate that the downstream stage accepts instr this cycle.
REQ-012 pc  output  32  SHALL be the address instr was fetched from.
REQ-013 branch  input  1  SHALL be the control-unit branch flag for the presented instruction.
REQ-014 zero  input  1  SHALL be the ALU zero flag for the presented instruction.
REQ-015 branch_offset  input  32  SHALL be the sign-extended word offset of the presented instruction.
REQ-016 fetch_err  output  1  SHALL be the sticky memory-timeout error flag.

Function
REQ-017 FSM states SHALL be IDLE, REQ, VALID and ERR.
REQ-018 IDLE SHALL advance to REQ unconditionally on the next clock edge.
REQ-019 In REQ: imem_req=1 and imem_addr=next_pc; on a sampled imem_ack the block SHALL capture instr<=imem_rdata and pc<=next_pc, then go to VALID.
REQ-020 In VALID: instr_valid=1 and imem_req=0; instr, pc and next_pc SHALL hold stable until instr_valid && instr_ready.
REQ-021 On VALID handshake: next_pc<=pc+4+(branch_offset<<2) if branch && zero, else pc+4; go to REQ.
REQ-022 branch, zero and branch_offset SHALL be sampled only in the handshake cycle and ignored otherwise.
REQ-023 PC arithmetic SHALL be modulo 2^32, so 32'hFFFFFFFC+4 wraps to 32'h00000000; negative offsets SHALL be handled by two's-complement addition.
REQ-024 imem_ack outside REQ SHALL be ignored.
REQ-025 A wait counter SHALL clear on REQ entry and increment each REQ cycle without ack.
REQ-026 On the ACK_TIMEOUT-th consecutive unacknowledged cycle, the FSM SHALL go to ERR with fetch_err=1.
REQ-027 An ack in the same cycle the counter would reach ACK_TIMEOUT SHALL win: the instruction is captured and no error is raised.
REQ-028 ERR SHALL hold imem_req=0, instr_valid=0 and fetch_err=1 until reset.
REQ-029 Fetch latency SHALL be one cycle: ack sampled at edge N gives instr_valid=1 in cycle N+1.

Reset
REQ-030 On rst asserted, asynchronously and regardless of state: state=IDLE, next_pc=RESET_PC, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, fetch_err=0, wait counter=0.
REQ-031 Reset asserted mid-fetch or mid-handshake SHALL abandon the transaction; a late ack after release SHALL be ignored unless the FSM is in REQ.
REQ-032 The first imem_req SHALL assert one cycle after rst deasserts, with imem_addr=RESET_PC.

Configuration
REQ-033 Macro FETCH_BRANCH_EN defined: branch redirect SHALL operate per REQ-021.
REQ-034 Macro FETCH_BRANCH_EN undefined: branch, zero and branch_offset SHALL be ignored and next_pc SHALL always be pc+4.

Verification
REQ-035 Reset release, imem_ack=1 in the first REQ cycle, rdata=32'h00000024 -> instr=32'h00000024, pc=0, instr_valid=1 one cycle later.
REQ-036 Handshake with branch=0, pc=32'h00000010 -> next imem_addr=32'h00000014.
REQ-037 FETCH_BRANCH_EN defined, pc=32'h00000010, branch=1, zero=1, offset=32'hFFFFFFFE -> imem_addr=32'h0000000C; with zero=0 -> 32'h00000014; macro undefined -> 32'h00000014.
REQ-038 instr_ready=0 for 5 cycles in VALID -> instr, pc and instr_valid stable, imem_req=0; ready=1 -> REQ on the next cycle.
REQ-039 ACK_TIMEOUT=16 with no ack -> fetch_err=1 after 16 REQ cycles; ack exactly at cycle 16 -> capture, fetch_err=0.
REQ-040 pc=32'hFFFFFFFC, branch=0 handshake -> imem_addr=32'h00000000; rst pulsed during REQ -> state IDLE, then imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch FSM with one-deep holding register and ack timeout
// Optional branch redirect enabled by defining FETCH_BRANCH_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc,
  input  logic        branch,
  input  logic        zero,
  input  logic [31:0] branch_offset,
  output logic        fetch_err
);

  typedef enum logic [1:0] {IDLE, REQ, VALID, ERR} state_t;

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};
  localparam logic [7:0]  TIMEOUT_CNT      = 8'(ACK_TIMEOUT);

  state_t      state_q, state_d;
  logic [31:0] next_pc_q, next_pc_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        instr_valid_q, instr_valid_d;
  logic        imem_req_q, imem_req_d;
  logic        fetch_err_q, fetch_err_d;
  logic [7:0]  wait_q, wait_d;
  logic [7:0]  wait_inc;
  logic [31:0] target_pc;

  assign wait_inc = wait_q + 8'd1;

`ifdef FETCH_BRANCH_EN
  assign target_pc = pc_q + 32'd4 + ((branch && zero) ? (branch_offset << 2) : 32'd0);
`else
  logic unused_branch_inputs;
  assign unused_branch_inputs = ^{branch, zero, branch_offset};
  assign target_pc = pc_q + 32'd4;
`endif

  always_comb begin
    state_d       = state_q;
    next_pc_d     = next_pc_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    imem_req_d    = imem_req_q;
    fetch_err_d   = fetch_err_q;
    wait_d        = wait_q;
    case (state_q)
      IDLE: begin
        state_d    = REQ;
        imem_req_d = 1'b1;
        wait_d     = 8'd0;
      end
      REQ: begin
        if (imem_ack) begin
          instr_d       = imem_rdata;
          pc_d          = next_pc_q;
          instr_valid_d = 1'b1;
          imem_req_d    = 1'b0;
          state_d       = VALID;
        end else if (wait_inc == TIMEOUT_CNT) begin
          // An ack on the final allowed cycle is handled above and wins over the timeout.
          imem_req_d  = 1'b0;
          fetch_err_d = 1'b1;
          state_d     = ERR;
        end else begin
          wait_d = wait_inc;
        end
      end
      VALID: begin
        if (instr_ready) begin
          next_pc_d     = target_pc;
          instr_valid_d = 1'b0;
          imem_req_d    = 1'b1;
          wait_d        = 8'd0;
          state_d       = REQ;
        end
      end
      ERR: begin
        imem_req_d    = 1'b0;
        instr_valid_d = 1'b0;
        fetch_err_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      next_pc_q     <= RESET_PC_ALIGNED;
      pc_q          <= RESET_PC_ALIGNED;
      instr_q       <= 32'd0;
      instr_valid_q <= 1'b0;
      imem_req_q    <= 1'b0;
      fetch_err_q   <= 1'b0;
      wait_q        <= 8'd0;
    end else begin
      state_q       <= state_d;
      next_pc_q     <= next_pc_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      imem_req_q    <= imem_req_d;
      fetch_err_q   <= fetch_err_d;
      wait_q        <= wait_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = next_pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;
  assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_ready;
  logic        branch;
  logic        zero;
  logic [31:0] branch_offset;

  logic        imem_req, instr_valid, fetch_err;
  logic [31:0] imem_addr, instr, pc;
  logic        w_req, w_valid, w_err;
  logic [31:0] w_addr, w_instr, w_pc;

  int vectors;
  int miscompares;

  fetch_unit #(.RESET_PC(32'h0000_0000), .ACK_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .pc(pc),
    .branch(branch), .zero(zero), .branch_offset(branch_offset),
    .fetch_err(fetch_err)
  );

  // Unaligned reset PC: the low two bits must be dropped.
  fetch_unit #(.RESET_PC(32'hFFFF_FFFF), .ACK_TIMEOUT(16)) dut_w (
    .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(w_instr),
    .instr_valid(w_valid), .instr_ready(instr_ready), .pc(w_pc),
    .branch(branch), .zero(zero), .branch_offset(branch_offset),
    .fetch_err(w_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'd0; instr_ready = 1'b0;
    branch = 1'b0; zero = 1'b0; branch_offset = 32'd0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (imem_req) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_fetch(input logic [31:0] d, output bit ok);
    wait_req(ok);
    imem_ack = 1'b1; imem_rdata = d;
    @(negedge clk);
    imem_ack = 1'b0; imem_rdata = 32'h0;
  endtask

  task automatic handshake(input logic b, input logic z, input logic [31:0] off);
    instr_ready = 1'b1; branch = b; zero = z; branch_offset = off;
    @(negedge clk);
    instr_ready = 1'b0; branch = 1'b1; zero = 1'b1; branch_offset = 32'h7FFF_FFFF;
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF; instr_ready = 1'b1;
    branch = 1'b0; zero = 1'b0; branch_offset = 32'd0;
    @(negedge clk);
    @(negedge clk);
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b want 0", imem_req); end
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    vectors++; if (fetch_err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", fetch_err); end
    vectors++; if (instr !== 32'd0) begin miscompares++; $display("FAIL reset_instr: got %h want 0", instr); end
    vectors++; if (pc !== 32'd0 || imem_addr !== 32'd0) begin miscompares++; $display("FAIL reset_pc: got pc %h addr %h want 0", pc, imem_addr); end
    vectors++; if (w_pc !== 32'hFFFF_FFFC || w_addr !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL reset_pc_align: got pc %h addr %h want fffffffc", w_pc, w_addr); end
    imem_ack = 1'b0; instr_ready = 1'b0;
  endtask

  task automatic test_first_fetch();
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin miscompares++; $display("FAIL first_req: got req %b addr %h want 1 00000000", imem_req, imem_addr); end
    imem_ack = 1'b1; imem_rdata = 32'h0000_0024;
    @(negedge clk);
    imem_ack = 1'b0;
    vectors++; if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin miscompares++; $display("FAIL first_valid: got valid %b req %b want 1 0", instr_valid, imem_req); end
    vectors++; if (instr !== 32'h0000_0024) begin miscompares++; $display("FAIL first_instr: got %h want 00000024", instr); end
    vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL first_pc: got %h want 00000000", pc); end
  endtask

  task automatic test_sequential();
    bit ok;
    for (int i = 0; i < 4; i++) begin
      handshake(1'b0, 1'b0, 32'h0);
      vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * (i + 1))) begin miscompares++; $display("FAIL seq_addr%0d: got req %b addr %h want 1 %h", i, imem_req, imem_addr, 32'(4 * (i + 1))); end
      do_fetch(32'h1000_0000 + 32'(i), ok);
      vectors++; if (!ok || pc !== 32'(4 * (i + 1)) || instr !== 32'h1000_0000 + 32'(i)) begin miscompares++; $display("FAIL seq_fetch%0d: got ok %b pc %h instr %h want pc %h", i, ok, pc, instr, 32'(4 * (i + 1))); end
    end
  endtask

  task automatic test_branch();
    bit ok;
    logic [31:0] exp_taken, exp_next;
`ifdef FETCH_BRANCH_EN
    exp_taken = 32'h0000_000C;
    exp_next  = 32'h0000_0010;
`else
    exp_taken = 32'h0000_0014;
    exp_next  = 32'h0000_0018;
`endif
    handshake(1'b1, 1'b1, 32'hFFFF_FFFE);
    vectors++; if (imem_addr !== exp_taken) begin miscompares++; $display("FAIL branch_taken: got %h want %h", imem_addr, exp_taken); end
    do_fetch(32'h2000_0001, ok);
    vectors++; if (!ok || pc !== exp_taken) begin miscompares++; $display("FAIL branch_fetch: got ok %b pc %h want %h", ok, pc, exp_taken); end
    handshake(1'b1, 1'b0, 32'hFFFF_FFFE);
    vectors++; if (imem_addr !== exp_next) begin miscompares++; $display("FAIL branch_zero0: got %h want %h", imem_addr, exp_next); end
    do_fetch(32'h2000_0002, ok);
    handshake(1'b0, 1'b0, 32'h0);
    vectors++; if (imem_addr !== exp_next + 32'd4) begin miscompares++; $display("FAIL branch_none: got %h want %h", imem_addr, exp_next + 32'd4); end
  endtask

  task automatic test_stall();
    bit ok;
    logic [31:0] exp_pc;
    exp_pc = imem_addr;
    do_fetch(32'hCAFE_0005, ok);
    for (int i = 0; i < 5; i++) begin
      imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0; branch = 1'b1; zero = 1'b1;
      vectors++; if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin miscompares++; $display("FAIL stall_ctl%0d: got valid %b req %b want 1 0", i, instr_valid, imem_req); end
      vectors++; if (instr !== 32'hCAFE_0005 || pc !== exp_pc) begin miscompares++; $display("FAIL stall_hold%0d: got instr %h pc %h want cafe0005 %h", i, instr, pc, exp_pc); end
      @(negedge clk);
    end
    imem_ack = 1'b0;
    handshake(1'b0, 1'b0, 32'h0);
    vectors++; if (imem_req !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== exp_pc + 32'd4) begin miscompares++; $display("FAIL stall_release: got req %b valid %b addr %h want 1 0 %h", imem_req, instr_valid, imem_addr, exp_pc + 32'd4); end
  endtask

  task automatic test_timeout();
    do_reset();
    @(negedge clk);
    for (int k = 1; k <= 16; k++) begin
      vectors++; if (imem_req !== 1'b1 || fetch_err !== 1'b0) begin miscompares++; $display("FAIL timeout_wait%0d: got req %b err %b want 1 0", k, imem_req, fetch_err); end
      @(negedge clk);
    end
    vectors++; if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin miscompares++; $display("FAIL timeout_err: got err %b req %b valid %b want 1 0 0", fetch_err, imem_req, instr_valid); end
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678; instr_ready = 1'b1;
    repeat (3) @(negedge clk);
    imem_ack = 1'b0; instr_ready = 1'b0;
    vectors++; if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin miscompares++; $display("FAIL timeout_sticky: got err %b req %b valid %b want 1 0 0", fetch_err, imem_req, instr_valid); end
  endtask

  task automatic test_ack_at_limit();
    do_reset();
    @(negedge clk);
    repeat (15) @(negedge clk);
    vectors++; if (imem_req !== 1'b1 || fetch_err !== 1'b0) begin miscompares++; $display("FAIL limit_req: got req %b err %b want 1 0", imem_req, fetch_err); end
    imem_ack = 1'b1; imem_rdata = 32'h0000_0016;
    @(negedge clk);
    imem_ack = 1'b0;
    vectors++; if (instr_valid !== 1'b1 || fetch_err !== 1'b0 || instr !== 32'h0000_0016) begin miscompares++; $display("FAIL limit_capture: got valid %b err %b instr %h want 1 0 00000016", instr_valid, fetch_err, instr); end
  endtask

  task automatic test_wrap_and_reset();
    bit ok;
    do_reset();
    do_fetch(32'h0000_0BEE, ok);
    vectors++; if (!ok || w_pc !== 32'hFFFF_FFFC || w_valid !== 1'b1) begin miscompares++; $display("FAIL wrap_fetch: got ok %b pc %h valid %b want fffffffc 1", ok, w_pc, w_valid); end
    handshake(1'b0, 1'b0, 32'h0);
    vectors++; if (w_addr !== 32'h0 || w_req !== 1'b1) begin miscompares++; $display("FAIL wrap_addr: got %h req %b want 00000000 1", w_addr, w_req); end
    #2 rst = 1'b1;
    #1;
    vectors++; if (imem_req !== 1'b0 || w_req !== 1'b0 || instr_valid !== 1'b0) begin miscompares++; $display("FAIL async_rst: got req %b wreq %b valid %b want 0 0 0", imem_req, w_req, instr_valid); end
    @(negedge clk);
    rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_ack = 1'b0;
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || w_addr !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL rst_restart: got req %b addr %h waddr %h want 1 00000000 fffffffc", imem_req, imem_addr, w_addr); end
    vectors++; if (instr_valid !== 1'b0 || instr !== 32'h0) begin miscompares++; $display("FAIL late_ack: got valid %b instr %h want 0 00000000", instr_valid, instr); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_first_fetch();
    test_sequential();
    test_branch();
    test_stall();
    test_timeout();
    test_ack_at_limit();
    test_wrap_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
